// File: rtl/irq_source_arbiter_pkg.sv
// Shared encodings for the interrupt source arbiter: FSM states, config
// register addresses, cause width and the fixed timer cause.
package irq_source_arbiter_pkg;

   localparam int CAUSE_W = 3;
   localparam logic [CAUSE_W-1:0] TIMER_CAUSE = 3'd7;

   localparam logic [1:0] CFG_MASK     = 2'd0;
   localparam logic [1:0] CFG_MTIMECMP = 2'd1;
   localparam logic [1:0] CFG_MTIME    = 2'd2;
   localparam logic [1:0] CFG_PENDING  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_ISSUE      = 3'd1,
      ST_WAIT_ACK   = 3'd2,
      ST_WAIT_DONE  = 3'd3,
      ST_IN_SERVICE = 3'd4
   } irq_state_t;

   // Fixed priority: the highest set index wins.
   function automatic logic [CAUSE_W-1:0] highest_index(input logic [7:0] vec);
      logic [CAUSE_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (vec[i]) idx = CAUSE_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/irq_source_arbiter_timer.sv
// Machine timer: free-running mtime, compare register mtimecmp, and a
// registered level flag that is high while mtime >= mtimecmp.
module irq_machine_timer
   import irq_source_arbiter_pkg::*;
#(
   parameter int TIMER_WIDTH = 32
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   rdy_in,
   input  logic                   cmp_write,
   input  logic                   time_write,
   input  logic [31:0]            write_data,
   output logic [TIMER_WIDTH-1:0] mtime,
   output logic [TIMER_WIDTH-1:0] mtimecmp,
   output logic                   timer_hit
);

   // Counter, compare register and registered compare; a software write to
   // mtime replaces that cycle's increment.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         mtime     <= '0;
         mtimecmp  <= '1;
         timer_hit <= 1'b0;
      end else if (rdy_in) begin
         timer_hit <= (mtime >= mtimecmp);
         if (time_write) mtime <= write_data[TIMER_WIDTH-1:0];
         else            mtime <= mtime + TIMER_WIDTH'(1);
         if (cmp_write) mtimecmp <= write_data[TIMER_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/irq_source_arbiter.sv
// Interrupt source arbiter: captures rising edges on external lines plus the
// machine-timer level, masks them, picks the highest cause and runs the
// request / stall-acknowledge / mret handshake with the interrupt controller.
module irq_source_arbiter
   import irq_source_arbiter_pkg::*;
#(
   parameter int NUM_EXT     = 7,
   parameter int TIMER_WIDTH = 32,
   parameter int ACK_TIMEOUT = 4
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               rdy_in,
   input  logic [NUM_EXT-1:0] ext_irq_in,
   input  logic               ctrl_stall_in,
   input  logic               mret_in,
   input  logic               cfg_write_enable,
   input  logic [1:0]         cfg_address,
   input  logic [31:0]        cfg_write_data,
   output logic [31:0]        cfg_read_data,
   output logic               interrupt_enable,
   output logic [2:0]         interrupt_cause,
   output logic [7:0]         pending_out,
   output logic               busy_out
);

   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

   irq_state_t           state, state_next;
   logic [CAUSE_W-1:0]   cause, cause_next;
   logic [CNT_W-1:0]     count, count_next;
   logic [7:0]           mask;
   logic [NUM_EXT-1:0]   ext_prev;
   logic [6:0]           ext_pend;
   logic [6:0]           set_vec;
   logic [6:0]           clear_vec;
   logic [7:0]           pending;
   logic [7:0]           eligible;
   logic                 service_clear;
   logic                 timer_hit;
   logic [TIMER_WIDTH-1:0] mtime;
   logic [TIMER_WIDTH-1:0] mtimecmp;

   logic cfg_active;
   logic write_mask;
   logic write_cmp;
   logic write_time;
   logic write_pending;

   assign cfg_active    = cfg_write_enable & rdy_in;
   assign write_mask    = cfg_active && (cfg_address == CFG_MASK);
   assign write_cmp     = cfg_active && (cfg_address == CFG_MTIMECMP);
   assign write_time    = cfg_active && (cfg_address == CFG_MTIME);
   assign write_pending = cfg_active && (cfg_address == CFG_PENDING);

   irq_machine_timer #(
      .TIMER_WIDTH (TIMER_WIDTH)
   ) u_timer (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .rdy_in     (rdy_in),
      .cmp_write  (write_cmp),
      .time_write (write_time),
      .write_data (cfg_write_data),
      .mtime      (mtime),
      .mtimecmp   (mtimecmp),
      .timer_hit  (timer_hit)
   );

   assign set_vec  = 7'(ext_irq_in & ~ext_prev);
   assign pending  = {timer_hit, ext_pend};
   assign eligible = pending & mask;

   // Clear sources for external pending bits: W1C writes and entry completion.
   always_comb begin
      clear_vec = '0;
      if (write_pending) clear_vec = cfg_write_data[6:0];
      if (service_clear && (cause != TIMER_CAUSE)) clear_vec[cause] = 1'b1;
   end

   // Edge capture, pending bits (a new edge beats a same-cycle clear) and mask.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         ext_prev <= '0;
         ext_pend <= '0;
         mask     <= '0;
      end else if (rdy_in) begin
         ext_prev <= ext_irq_in;
         ext_pend <= (ext_pend & ~clear_vec) | set_vec;
         if (write_mask) mask <= cfg_write_data[7:0];
      end
   end

   // Handshake state, latched cause and acknowledge timeout counter.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state <= ST_IDLE;
         cause <= '0;
         count <= '0;
      end else if (rdy_in) begin
         state <= state_next;
         cause <= cause_next;
         count <= count_next;
      end
   end

   // Next-state logic for the request / acknowledge / service sequence.
   always_comb begin
      state_next    = state;
      cause_next    = cause;
      count_next    = count;
      service_clear = 1'b0;
      case (state)
         ST_IDLE: begin
            if ((eligible != '0) && !ctrl_stall_in) begin
               state_next = ST_ISSUE;
               cause_next = highest_index(eligible);
            end
         end
         ST_ISSUE: begin
            state_next = ST_WAIT_ACK;
            count_next = CNT_W'(ACK_TIMEOUT);
         end
         ST_WAIT_ACK: begin
            if (ctrl_stall_in) begin
               state_next = ST_WAIT_DONE;
            end else if (count <= CNT_W'(1)) begin
               // Controller never took it: fall back and re-arbitrate.
               state_next = ST_IDLE;
               count_next = '0;
            end else begin
               count_next = count - CNT_W'(1);
            end
         end
         ST_WAIT_DONE: begin
            if (!ctrl_stall_in) begin
               state_next    = ST_IN_SERVICE;
               service_clear = 1'b1;
            end
         end
         ST_IN_SERVICE: begin
            if (mret_in) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Config read-back mux.
   always_comb begin
      case (cfg_address)
         CFG_MASK:     cfg_read_data = {24'h0, mask};
         CFG_MTIMECMP: cfg_read_data = 32'(mtimecmp);
         CFG_MTIME:    cfg_read_data = 32'(mtime);
         default:      cfg_read_data = {24'h0, pending};
      endcase
   end

   assign interrupt_enable = (state == ST_ISSUE);
   assign interrupt_cause  = cause;
   assign busy_out         = (state != ST_IDLE);
   assign pending_out      = pending;

endmodule

// File: tb/tb_irq_source_arbiter.sv
// Testbench for irq_source_arbiter: vector table for arbitration, directed
// multi-cycle sequences, and a randomized run against a reference model.
module tb_irq_source_arbiter;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        rdy_in = 1'b1;
   logic [6:0]  ext_irq_in = '0;
   logic        ctrl_stall_in = 1'b0;
   logic        mret_in = 1'b0;
   logic        cfg_write_enable = 1'b0;
   logic [1:0]  cfg_address = '0;
   logic [31:0] cfg_write_data = '0;
   logic [31:0] cfg_read_data;
   logic        interrupt_enable;
   logic [2:0]  interrupt_cause;
   logic [7:0]  pending_out;
   logic        busy_out;

   int total = 0;
   int bad   = 0;

   irq_source_arbiter #(
      .NUM_EXT     (7),
      .TIMER_WIDTH (32),
      .ACK_TIMEOUT (4)
   ) dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .rdy_in           (rdy_in),
      .ext_irq_in       (ext_irq_in),
      .ctrl_stall_in    (ctrl_stall_in),
      .mret_in          (mret_in),
      .cfg_write_enable (cfg_write_enable),
      .cfg_address      (cfg_address),
      .cfg_write_data   (cfg_write_data),
      .cfg_read_data    (cfg_read_data),
      .interrupt_enable (interrupt_enable),
      .interrupt_cause  (interrupt_cause),
      .pending_out      (pending_out),
      .busy_out         (busy_out)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1);
   end

   typedef struct {
      logic [6:0] ext;
      logic [7:0] hold;
      logic [7:0] go;
      logic [7:0] pend;
      logic [2:0] cause;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
      cfg_write_enable = 1'b1;
      cfg_address      = addr;
      cfg_write_data   = data;
      tick();
      cfg_write_enable = 1'b0;
   endtask

   task automatic pulse_ext(input logic [6:0] pattern);
      ext_irq_in = pattern;
      tick();
      ext_irq_in = '0;
   endtask

   task automatic wait_enable(input int max_cycles);
      logic found;
      found = 1'b0;
      for (int i = 0; i < max_cycles && !found; i++) begin
         tick();
         if (interrupt_enable === 1'b1) found = 1'b1;
      end
      check("req_seen", {31'h0, found}, 32'h1);
   endtask

   // Accept the request: stall rises, holds, falls; returns in IN_SERVICE.
   task automatic handshake();
      ctrl_stall_in = 1'b1;
      tick();
      tick();
      tick();
      ctrl_stall_in = 1'b0;
      tick();
   endtask

   task automatic do_mret();
      mret_in = 1'b1;
      tick();
      mret_in = 1'b0;
      check("mret_idle", {31'h0, busy_out}, 32'h0);
   endtask

   // Asserts reset mid-cycle and checks outputs immediately (asynchronous).
   task automatic do_reset();
      #3;
      rst_in           = 1'b0;
      rdy_in           = 1'b1;
      ext_irq_in       = '0;
      ctrl_stall_in    = 1'b0;
      mret_in          = 1'b0;
      cfg_write_enable = 1'b0;
      cfg_address      = 2'd0;
      #1;
      check("rst_enable",  {31'h0, interrupt_enable}, 32'h0);
      check("rst_cause",   {29'h0, interrupt_cause}, 32'h0);
      check("rst_pending", {24'h0, pending_out}, 32'h0);
      check("rst_busy",    {31'h0, busy_out}, 32'h0);
      check("rst_mask",    cfg_read_data, 32'h0);
      cfg_address = 2'd1;
      #1;
      check("rst_mtimecmp", cfg_read_data, 32'hFFFF_FFFF);
      cfg_address = 2'd2;
      #1;
      check("rst_mtime", cfg_read_data, 32'h0);
      cfg_address = 2'd0;
      tick();
      tick();
      rst_in = 1'b1;
   endtask

   // Reference model state for the randomized run.
   logic [7:0]  m_mask;
   logic [31:0] m_mtime;
   logic [31:0] m_cmp;
   logic        m_hit;
   bit          m_pend[7];
   bit          m_level[7];

   initial begin
      logic [31:0] v;
      logic [7:0]  exp_p;

      vecs[0] = '{ext: 7'h08, hold: 8'h04, go: 8'h08, pend: 8'h08, cause: 3'd3};
      vecs[1] = '{ext: 7'h22, hold: 8'h00, go: 8'hFF, pend: 8'h22, cause: 3'd5};
      vecs[2] = '{ext: 7'h41, hold: 8'h00, go: 8'h01, pend: 8'h41, cause: 3'd0};
      vecs[3] = '{ext: 7'h7F, hold: 8'h00, go: 8'h3C, pend: 8'h7F, cause: 3'd5};
      vecs[4] = '{ext: 7'h10, hold: 8'h00, go: 8'h90, pend: 8'h10, cause: 3'd4};
      vecs[5] = '{ext: 7'h09, hold: 8'hF6, go: 8'hFF, pend: 8'h09, cause: 3'd3};

      tick();

      // Single request on line 2: latency, one-cycle pulse, service, mret.
      do_reset();
      cfg_write(2'd0, 32'hFF);
      pulse_ext(7'h04);
      check("t1_pend_set", {24'h0, pending_out}, 32'h04);
      check("t1_no_req_yet", {31'h0, interrupt_enable}, 32'h0);
      tick();
      check("t1_req", {31'h0, interrupt_enable}, 32'h1);
      check("t1_cause", {29'h0, interrupt_cause}, 32'h2);
      tick();
      check("t1_single_pulse", {31'h0, interrupt_enable}, 32'h0);
      ctrl_stall_in = 1'b1;
      for (int i = 0; i < 11; i++) tick();
      ctrl_stall_in = 1'b0;
      tick();
      check("t1_pend_clr", {31'h0, pending_out[2]}, 32'h0);
      check("t1_busy", {31'h0, busy_out}, 32'h1);
      tick();
      tick();
      check("t1_busy_hold", {31'h0, busy_out}, 32'h1);
      check("t1_no_nest", {31'h0, interrupt_enable}, 32'h0);
      do_mret();

      // Simultaneous edges on lines 1 and 5.
      do_reset();
      cfg_write(2'd0, 32'hFF);
      pulse_ext(7'h22);
      wait_enable(4);
      check("t2_first_cause", {29'h0, interrupt_cause}, 32'h5);
      handshake();
      check("t2_pend_left", {24'h0, pending_out}, 32'h02);
      do_mret();
      wait_enable(4);
      check("t2_second_cause", {29'h0, interrupt_cause}, 32'h1);
      handshake();
      check("t2_pend_none", {24'h0, pending_out}, 32'h00);
      do_mret();

      // Table of mask / edge patterns.
      do_reset();
      for (int k = 0; k < 6; k++) begin
         logic saw;
         cfg_write(2'd0, {24'h0, vecs[k].hold});
         pulse_ext(vecs[k].ext);
         check("vec_pend", {24'h0, pending_out}, {24'h0, vecs[k].pend});
         saw = 1'b0;
         for (int i = 0; i < 3; i++) begin
            tick();
            if (interrupt_enable === 1'b1 || busy_out === 1'b1) saw = 1'b1;
         end
         check("vec_masked_quiet", {31'h0, saw}, 32'h0);
         cfg_write(2'd0, {24'h0, vecs[k].go});
         wait_enable(6);
         check("vec_cause", {29'h0, interrupt_cause}, {29'h0, vecs[k].cause});
         handshake();
         exp_p = vecs[k].pend;
         exp_p[vecs[k].cause] = 1'b0;
         check("vec_pend_after", {24'h0, pending_out}, {24'h0, exp_p});
         cfg_write(2'd0, 32'h0);
         do_mret();
         cfg_write(2'd3, 32'h7F);
         check("vec_w1c", {24'h0, pending_out}, 32'h0);
      end

      // Timer compare request.
      do_reset();
      cfg_write(2'd0, 32'h80);
      cfg_write(2'd1, 32'd20);
      cfg_write(2'd2, 32'd0);
      for (int j = 1; j <= 21; j++) begin
         tick();
         if (j >= 19) check("t4_timer_level", {31'h0, pending_out[7]}, {31'h0, (j == 21)});
      end
      tick();
      check("t4_req", {31'h0, interrupt_enable}, 32'h1);
      check("t4_cause", {29'h0, interrupt_cause}, 32'h7);
      handshake();
      check("t4_timer_not_cleared", {31'h0, pending_out[7]}, 32'h1);
      cfg_write(2'd1, 32'hFFFF_FFFF);
      tick();
      check("t4_timer_dropped", {31'h0, pending_out[7]}, 32'h0);
      do_mret();

      // Acknowledge timeout, retry, freeze and reset inside WAIT_DONE.
      do_reset();
      cfg_write(2'd0, 32'hFF);
      pulse_ext(7'h10);
      wait_enable(4);
      check("t5_cause", {29'h0, interrupt_cause}, 32'h4);
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k < 6) check("t5_no_req", {31'h0, interrupt_enable}, 32'h0);
         if (k == 4) check("t5_still_waiting", {31'h0, busy_out}, 32'h1);
         if (k == 5) begin
            check("t5_timeout_idle", {31'h0, busy_out}, 32'h0);
            check("t5_pend_kept", {31'h0, pending_out[4]}, 32'h1);
         end
      end
      check("t5_retry_req", {31'h0, interrupt_enable}, 32'h1);
      check("t5_retry_cause", {29'h0, interrupt_cause}, 32'h4);
      tick();
      cfg_address = 2'd2;
      rdy_in = 1'b0;
      #1;
      v = cfg_read_data;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("t6_frozen_busy", {31'h0, busy_out}, 32'h1);
         check("t6_frozen_mtime", cfg_read_data, v);
      end
      rdy_in = 1'b1;
      tick();
      check("t6_mtime_resume", cfg_read_data, v + 32'd1);
      tick();
      tick();
      check("t6_counter_held", {31'h0, busy_out}, 32'h1);
      tick();
      check("t6_timeout_after_freeze", {31'h0, busy_out}, 32'h0);
      tick();
      check("t6_req_again", {31'h0, interrupt_enable}, 32'h1);
      ctrl_stall_in = 1'b1;
      tick();
      tick();
      check("t6_wait_done_busy", {31'h0, busy_out}, 32'h1);
      check("t6_cause_before_rst", {29'h0, interrupt_cause}, 32'h4);
      do_reset();

      // Randomized run with mask left at 0 so the handshake stays idle.
      m_mask  = '0;
      m_mtime = '0;
      m_cmp   = 32'hFFFF_FFFF;
      m_hit   = 1'b0;
      for (int i = 0; i < 7; i++) begin
         m_pend[i]  = 1'b0;
         m_level[i] = 1'b0;
      end
      for (int it = 0; it < 400; it++) begin
         logic        we;
         logic [1:0]  addr;
         logic [31:0] wd;
         logic [7:0]  p;
         logic [31:0] rd;
         logic        hit_now;
         ext_irq_in = 7'($urandom);
         rdy_in     = ($urandom_range(0, 4) != 0);
         we         = ($urandom_range(0, 2) == 0);
         addr       = we ? 2'($urandom_range(1, 3)) : 2'($urandom_range(0, 3));
         case (addr)
            2'd1:    wd = 32'($urandom_range(0, 60));
            2'd2:    wd = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 60))
                                                      : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            default: wd = $urandom;
         endcase
         cfg_write_enable = we;
         cfg_address      = addr;
         cfg_write_data   = wd;
         tick();
         if (rdy_in) begin
            hit_now = (m_mtime >= m_cmp);
            for (int b = 0; b < 7; b++) begin
               if (we && addr == 2'd3 && wd[b]) m_pend[b] = 1'b0;
               if (ext_irq_in[b] && !m_level[b]) m_pend[b] = 1'b1;
               m_level[b] = ext_irq_in[b];
            end
            if (we && addr == 2'd2) m_mtime = wd;
            else                    m_mtime = m_mtime + 32'd1;
            if (we && addr == 2'd1) m_cmp = wd;
            m_hit = hit_now;
         end
         p[7] = m_hit;
         for (int b = 0; b < 7; b++) p[b] = m_pend[b];
         case (addr)
            2'd0:    rd = {24'h0, m_mask};
            2'd1:    rd = m_cmp;
            2'd2:    rd = m_mtime;
            default: rd = {24'h0, p};
         endcase
         check("rnd_pending", {24'h0, pending_out}, {24'h0, p});
         check("rnd_read", cfg_read_data, rd);
         check("rnd_idle", {30'h0, busy_out, interrupt_enable}, 32'h0);
      end
      cfg_write_enable = 1'b0;
      rdy_in = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
